// File: rtl/seg7_pkg.sv
// seg7_pkg: segment constants, receiver FSM state type and the pattern decoder.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    // Returns {valid, digit}; any pattern outside the table decodes as invalid.
    function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0_0000;
        case (seg)
            SEG_0:   res = {1'b1, 4'h0};
            SEG_1:   res = {1'b1, 4'h1};
            SEG_2:   res = {1'b1, 4'h2};
            SEG_3:   res = {1'b1, 4'h3};
            SEG_4:   res = {1'b1, 4'h4};
            SEG_5:   res = {1'b1, 4'h5};
            SEG_6:   res = {1'b1, 4'h6};
            SEG_7:   res = {1'b1, 4'h7};
            SEG_8:   res = {1'b1, 4'h8};
            SEG_9:   res = {1'b1, 4'h9};
            SEG_A:   res = {1'b1, 4'hA};
            SEG_B:   res = {1'b1, 4'hB};
            SEG_C:   res = {1'b1, 4'hC};
            SEG_D:   res = {1'b1, 4'hD};
            SEG_E:   res = {1'b1, 4'hE};
            SEG_F:   res = {1'b1, 4'hF};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_stab.sv
// seg7_stab: registers the segment bus once and counts how many consecutive
// cycles the registered value has stayed the same. stable_hit_o is high for
// exactly one cycle, when the count first reaches STABLE.
module seg7_stab #(
    parameter int unsigned STABLE = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] seg_i,
    output logic [6:0] seg_q_o,
    output logic       stable_hit_o
);

    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] HIT_CNT = CW'(STABLE);
    localparam logic [CW-1:0] SAT_CNT = CW'(STABLE + 1);

    logic [CW-1:0] st_cnt_q;

    // Input register and run-length counter; the count parks one past STABLE
    // so the hit can only fire once per stable run.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_q_o  <= 7'd0;
            st_cnt_q <= '0;
        end else if (seg_i != seg_q_o) begin
            seg_q_o  <= seg_i;
            st_cnt_q <= CW'(1);
        end else if (st_cnt_q != SAT_CNT) begin
            st_cnt_q <= st_cnt_q + CW'(1);
        end
    end

    assign stable_hit_o = (st_cnt_q == HIT_CNT);

endmodule

// File: rtl/seg7_rx.sv
// seg7_rx: seven-segment receive/decode. Accepts a digit once the bus has been
// stable for STABLE clocks and flags invalid patterns with a sticky Err and a
// saturating ErrCnt.
// Optional feature macro: SEG7_RX_SEQ_CHECK_EN -- when defined, each accepted
// digit in LOCK must equal the previous one +1 mod 16, otherwise it is a fault.
module seg7_rx #(
    parameter int unsigned STABLE = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [6:0]       Seg,
    input  logic             Clr,
    output logic [3:0]       Digit,
    output logic             Valid,
    output logic             Strobe,
    output logic             Err,
    output logic [CNT_W-1:0] ErrCnt
);

    import seg7_pkg::*;

    logic [6:0] seg_q;
    logic       stable_hit;
    logic [4:0] dec;
    logic       dec_valid;
    logic [3:0] dec_digit;
    state_t     state;

    seg7_stab #(
        .STABLE(STABLE)
    ) u_stab (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .seg_i       (Seg),
        .seg_q_o     (seg_q),
        .stable_hit_o(stable_hit)
    );

    assign dec       = seg7_decode(seg_q);
    assign dec_valid = dec[4];
    assign dec_digit = dec[3:0];

`ifdef SEG7_RX_SEQ_CHECK_EN
    logic [3:0] exp_digit;
    assign exp_digit = Digit + 4'd1;
`endif

    // Acceptance FSM with registered outputs; Clr overrides any same-cycle fault.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            Digit  <= 4'd0;
            Valid  <= 1'b0;
            Strobe <= 1'b0;
            Err    <= 1'b0;
            ErrCnt <= '0;
        end else begin
            Strobe <= 1'b0;
            if (Clr) begin
                // Digit is kept; returning to IDLE makes the next digit unchecked.
                state  <= IDLE;
                Valid  <= 1'b0;
                Err    <= 1'b0;
                ErrCnt <= '0;
            end else if (stable_hit) begin
                case (state)
                    IDLE: begin
                        if (dec_valid) begin
                            state  <= LOCK;
                            Digit  <= dec_digit;
                            Valid  <= 1'b1;
                            Strobe <= 1'b1;
                        end
                    end
                    LOCK: begin
                        if (!dec_valid) begin
                            state <= IDLE;
                            Valid <= 1'b0;
                            Err   <= 1'b1;
                            if (ErrCnt != '1) ErrCnt <= ErrCnt + CNT_W'(1);
                        end else if (dec_digit != Digit) begin
                            Digit  <= dec_digit;
                            Strobe <= 1'b1;
`ifdef SEG7_RX_SEQ_CHECK_EN
                            if (dec_digit != exp_digit) begin
                                Err <= 1'b1;
                                if (ErrCnt != '1) ErrCnt <= ErrCnt + CNT_W'(1);
                            end
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_rx.sv
// tb_seg7_rx: directed stimulus with a scoreboard. The stimulus process pushes
// the expected output snapshot (and the cycle it must appear on); the monitor
// pops one entry whenever Strobe pulses or Valid/Err/ErrCnt change.
module tb_seg7_rx;

    localparam int unsigned STABLE = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int LAT = STABLE + 1;  // from driving Seg to the accepting edge

`ifdef SEG7_RX_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct {
        string            name;
        logic [3:0]       digit;
        logic             valid;
        logic             strobe;
        logic             err;
        logic [CNT_W-1:0] cnt;
        int               cyc;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [6:0]       Seg = 7'd0;
    logic             Clr = 1'b0;
    logic [3:0]       Digit;
    logic             Valid;
    logic             Strobe;
    logic             Err;
    logic [CNT_W-1:0] ErrCnt;

    exp_t             exp_q[$];
    exp_t             cur;
    int               cyc      = 0;
    int               checks   = 0;
    int               failures = 0;
    bit               done     = 1'b0;
    logic             pv       = 1'b0;
    logic             pe       = 1'b0;
    logic [CNT_W-1:0] pc       = '0;

    seg7_rx #(
        .STABLE(STABLE),
        .CNT_W (CNT_W)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Seg   (Seg),
        .Clr   (Clr),
        .Digit (Digit),
        .Valid (Valid),
        .Strobe(Strobe),
        .Err   (Err),
        .ErrCnt(ErrCnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic expect_ev(input string name, input logic [3:0] d, input logic v,
                             input logic s, input logic e, input logic [CNT_W-1:0] c,
                             input int dcyc);
        exp_t x;
        x.name   = name;
        x.digit  = d;
        x.valid  = v;
        x.strobe = s;
        x.err    = e;
        x.cnt    = c;
        x.cyc    = cyc + dcyc;
        exp_q.push_back(x);
    endtask

    // Called just after a rising edge; drives Seg and waits n edges.
    task automatic hold(input logic [6:0] p, input int n);
        Seg = p;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_clr();
        Clr = 1'b1;
        @(posedge Clk);
        #1;
        Clr = 1'b0;
    endtask

    // Monitor: checks reset values while Rst is high, otherwise scoreboards events.
    always @(negedge Clk) begin
        if (Rst) begin
            checks++;
            if (Digit !== 4'd0 || Valid !== 1'b0 || Strobe !== 1'b0 || Err !== 1'b0 ||
                ErrCnt !== '0) begin
                failures++;
                $display("FAIL reset: got digit=%0h valid=%0b strobe=%0b err=%0b errcnt=%0d, want all zero",
                         Digit, Valid, Strobe, Err, ErrCnt);
            end
        end else if (Strobe !== 1'b0 || Valid !== pv || Err !== pe || ErrCnt !== pc) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d: got digit=%0h valid=%0b strobe=%0b err=%0b errcnt=%0d, want no event",
                         cyc, Digit, Valid, Strobe, Err, ErrCnt);
            end else begin
                cur = exp_q.pop_front();
                if (Digit !== cur.digit || Valid !== cur.valid || Strobe !== cur.strobe ||
                    Err !== cur.err || ErrCnt !== cur.cnt || cyc != cur.cyc) begin
                    failures++;
                    $display("FAIL %s: got digit=%0h valid=%0b strobe=%0b err=%0b errcnt=%0d cyc=%0d, want digit=%0h valid=%0b strobe=%0b err=%0b errcnt=%0d cyc=%0d",
                             cur.name, Digit, Valid, Strobe, Err, ErrCnt, cyc,
                             cur.digit, cur.valid, cur.strobe, cur.err, cur.cnt, cur.cyc);
                end
            end
        end
        pv = Valid;
        pe = Err;
        pc = ErrCnt;
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL missing_event: got %0d expected events never seen, want 0 (first %s)",
                         exp_q.size(), exp_q[0].name);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Stimulus
    initial begin
        int               prev_d;
        int               d;
        logic [CNT_W-1:0] c;
        logic [6:0]       bad;

        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;

        // First acceptance: LAT cycles after the drive, unchecked.
        expect_ev("first_lock", 4'h0, 1'b1, 1'b1, 1'b0, '0, LAT);
        hold(SEG_TAB[0], 10);

        // Count 1..F then wrap to 0: all legal.
        for (int i = 1; i <= 16; i++) begin
            expect_ev("count_seq", 4'(i), 1'b1, 1'b1, 1'b0, '0, LAT);
            hold(SEG_TAB[i % 16], 8);
        end

        // Lock at 3, then skip to 5.
        for (int i = 1; i <= 3; i++) begin
            expect_ev("to_three", 4'(i), 1'b1, 1'b1, 1'b0, '0, LAT);
            hold(SEG_TAB[i], 8);
        end
        expect_ev("seq_skip", 4'h5, 1'b1, 1'b1, SEQ, CNT_W'(SEQ), LAT);
        hold(SEG_TAB[5], 8);
        expect_ev("clr_after_skip", 4'h5, 1'b0, 1'b0, 1'b0, '0, 1);
        pulse_clr();
        hold(SEG_TAB[5], 3);

        // Glitch to 8 for two cycles while locked at 7: ignored.
        expect_ev("lock7", 4'h7, 1'b1, 1'b1, 1'b0, '0, LAT);
        hold(SEG_TAB[7], 8);
        hold(SEG_TAB[8], 2);
        hold(SEG_TAB[7], 8);

        // Invalid pattern while locked at 2, then relock at 0 unchecked.
        expect_ev("clr7", 4'h7, 1'b0, 1'b0, 1'b0, '0, 1);
        pulse_clr();
        expect_ev("lock2", 4'h2, 1'b1, 1'b1, 1'b0, '0, LAT);
        hold(SEG_TAB[2], 8);
        expect_ev("bad_pattern", 4'h2, 1'b0, 1'b0, 1'b1, CNT_W'(1), LAT);
        hold(7'b0000001, 8);
        expect_ev("relock0", 4'h0, 1'b1, 1'b1, 1'b1, CNT_W'(1), LAT);
        hold(SEG_TAB[0], 8);

        // Drive the fault count past all-ones.
        prev_d = 0;
        for (int k = 2; k <= 260; k++) begin
            c   = (k > 255) ? CNT_W'(255) : CNT_W'(k);
            bad = (k % 2 == 1) ? 7'b0000001 : 7'b0000000;
            expect_ev("sat_fault", 4'(prev_d), 1'b0, 1'b0, 1'b1, c, LAT);
            hold(bad, 6);
            d = k % 16;
            expect_ev("sat_relock", 4'(d), 1'b1, 1'b1, 1'b1, c, LAT);
            hold(SEG_TAB[d], 6);
            prev_d = d;
        end

        // Clr on the same edge as an invalid-pattern fault: Clr wins.
        expect_ev("clr_wins", 4'(prev_d), 1'b0, 1'b0, 1'b0, '0, LAT);
        Seg = 7'b0000001;
        repeat (STABLE) @(posedge Clk);
        #1;
        Clr = 1'b1;
        @(posedge Clk);
        #1;
        Clr = 1'b0;
        hold(7'b0000001, 4);

        // Rst two cycles into a stabilisation, then a fresh 6 is accepted unchecked.
        Seg = SEG_TAB[3];
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
        Seg = SEG_TAB[6];
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        expect_ev("post_reset_6", 4'h6, 1'b1, 1'b1, 1'b0, '0, LAT);
        hold(SEG_TAB[6], 8);

        repeat (4) @(posedge Clk);
        #1;
        done = 1'b1;
    end

endmodule
